// File: rtl/ibex_pkg.sv
// ibex_pkg: shared load/store types and helpers for the data access unit
package ibex_pkg;

    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10
    } ls_type_e;

    function automatic logic ls_split(ls_type_e t, logic [1:0] o);
        return (t == LS_WORD && o != 2'b00) || (t == LS_HALF && o == 2'b11);
    endfunction

endpackage

// File: rtl/ibex_lsu_rdata_ext.sv
// ibex_lsu_rdata_ext: aligns, truncates and extends load data for writeback
module ibex_lsu_rdata_ext
    import ibex_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] rdata_q,
    input  logic        split,
    input  logic [1:0]  offset,
    input  ls_type_e    ls_type,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  sh;
    logic [31:0] al;

    assign hi = split ? rdata : 32'h0;
    assign lo = split ? rdata_q : rdata;
    assign sh = {offset, 3'b000};
    assign al = (lo >> sh) | (hi << (6'd32 - {1'b0, sh}));

    assign data = ls_type == LS_WORD ? al :
                  ls_type == LS_HALF ? {{16{sign_ext & al[15]}}, al[15:0]} :
                                       {{24{sign_ext & al[7]}}, al[7:0]};

endmodule

// File: rtl/ibex_data_access_unit.sv
// ibex_data_access_unit: load/store bus sequencer with misaligned access splitting
module ibex_data_access_unit
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_req_done_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, sext_q, err_q;
    ls_type_e    type_q;
    logic [1:0]  off_q;
    logic [29:0] word_q;
    logic [31:0] wdata_q, rdata_q;

    logic        idle, start, second, cur_we, cur_split, final_req;
    ls_type_e    cur_type;
    logic [1:0]  cur_off;
    logic [29:0] cur_word;
    logic [31:0] cur_wdata;
    logic [3:0]  be_first, be_second;
    logic [4:0]  sh;

    assign idle      = state_q == IDLE;
    assign start     = idle & lsu_req_i & rst_ni;
    assign cur_we    = idle ? lsu_we_i : we_q;
    assign cur_type  = idle ? ls_type_e'(lsu_type_i) : type_q;
    assign cur_off   = idle ? lsu_addr_i[1:0] : off_q;
    assign cur_word  = idle ? lsu_addr_i[31:2] : word_q;
    assign cur_wdata = idle ? lsu_wdata_i : wdata_q;
    assign cur_split = ls_split(cur_type, cur_off);

    // The second half is addressed from WAIT_RVALID_MIS (issued with the first response) or a stalled WAIT_GNT
    assign second    = (state_q == WAIT_RVALID_MIS) | ((state_q == WAIT_GNT) & cur_split);
    assign final_req = ~cur_split | second;

    assign be_first  = cur_type == LS_WORD ? 4'b1111 << cur_off :
                       cur_type == LS_HALF ? 4'b0011 << cur_off :
                                             4'b0001 << cur_off;
    assign be_second = cur_type == LS_WORD ? ~be_first : 4'b0001;
    assign sh        = {cur_off, 3'b000};

    assign data_addr_o  = {cur_word + {29'b0, second}, 2'b00};
    assign data_we_o    = cur_we;
    assign data_be_o    = second ? be_second : be_first;
    assign data_wdata_o = (cur_wdata << sh) | (cur_wdata >> (6'd32 - {1'b0, sh}));

    assign lsu_busy_o     = ~idle;
    assign lsu_req_done_o = data_req_o & data_gnt_i & final_req;
    assign lsu_resp_err_o = lsu_resp_valid_o & (data_err_i | (cur_split & err_q));
    assign rf_we_lsu_o    = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o;

    // Next state, bus request and response strobe
    always_comb begin
        state_d          = state_q;
        data_req_o       = 1'b0;
        lsu_resp_valid_o = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                data_req_o = 1'b1;
                state_d    = data_gnt_i ? (cur_split ? WAIT_RVALID_MIS : WAIT_RVALID)
                                        : (cur_split ? WAIT_GNT_MIS : WAIT_GNT);
            end
            WAIT_GNT_MIS: begin
                data_req_o = 1'b1;
                state_d    = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
            end
            WAIT_RVALID_MIS: if (data_rvalid_i) begin
                data_req_o = 1'b1;
                state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_RVALID: if (data_rvalid_i) begin
                lsu_resp_valid_o = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Access attributes captured when a request is accepted in IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            type_q  <= LS_WORD;
            sext_q  <= 1'b0;
            off_q   <= 2'b00;
            word_q  <= 30'h0;
            wdata_q <= 32'h0;
        end else if (start) begin
            we_q    <= lsu_we_i;
            type_q  <= ls_type_e'(lsu_type_i);
            sext_q  <= lsu_sign_ext_i;
            off_q   <= lsu_addr_i[1:0];
            word_q  <= lsu_addr_i[31:2];
            wdata_q <= lsu_wdata_i;
        end
    end

    // First-half response of a split access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state_q == WAIT_RVALID_MIS && data_rvalid_i) begin
            rdata_q <= data_rdata_i;
            err_q   <= data_err_i;
        end
    end

    ibex_lsu_rdata_ext u_rdata_ext (
        .rdata    (data_rdata_i),
        .rdata_q  (rdata_q),
        .split    (cur_split),
        .offset   (off_q),
        .ls_type  (type_q),
        .sign_ext (sext_q),
        .data     (rf_wdata_lsu_o)
    );

endmodule
